// File: rtl/exec_run_ctrl_if.sv
// Host command port for exec_run_ctrl: valid/ready handshake carrying an
// opcode (0 HALT, 1 RUN, 2 STEP, 3 CLEAR) and a step count.
interface exec_run_ctrl_if #(
    parameter int STEP_W = 16
);
    logic              valid;
    logic              ready;
    logic [1:0]        op;
    logic [STEP_W-1:0] step_cnt;

    modport master (
        output valid,
        output op,
        output step_cnt,
        input  ready
    );

    modport slave (
        input  valid,
        input  op,
        input  step_cnt,
        output ready
    );
endinterface

// File: rtl/exec_run_ctrl.sv
// Run/step/halt sequencer driving the datapath PC-advance enable.
// Ports: clk_i, rst_i (async, active-high), cmd (host command interface),
//   pc_i/instr_i (current PC and its instruction), bkpt_valid_i/bkpt_pc_i,
//   en_o (retire enable), state_o, cause_o (last halt cause), retired_o.
// Macro EXEC_RUN_CTRL_BKPT_EN enables the PC breakpoint compare.
module exec_run_ctrl #(
    parameter int          PC_W       = 9,
    parameter int          STEP_W     = 16,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    exec_run_ctrl_if.slave   cmd,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [31:0]      instr_i,
    input  logic             bkpt_valid_i,
    input  logic [PC_W-1:0]  bkpt_pc_i,
    output logic             en_o,
    output logic [1:0]       state_o,
    output logic [1:0]       cause_o,
    output logic [31:0]      retired_o
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [1:0] OP_HALT  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_STEP  = 2'd1;
    localparam logic [1:0] C_HINST = 2'd2;
    localparam logic [1:0] C_BKPT  = 2'd3;

    state_t            state, state_n;
    logic [1:0]        cause, cause_n;
    logic [31:0]       retired, retired_n;
    logic [STEP_W-1:0] remaining, remaining_n;
    logic              skip, skip_n;

    logic halt_word;
    logic bkpt_match;
    logic stop_hit;
    logic fire;

    assign halt_word = (instr_i == HALT_INSTR);

`ifdef EXEC_RUN_CTRL_BKPT_EN
    assign bkpt_match = bkpt_valid_i & (pc_i == bkpt_pc_i);
`else
    logic unused_bkpt;
    assign unused_bkpt = bkpt_valid_i ^ (^bkpt_pc_i);
    assign bkpt_match  = 1'b0;
`endif

    // skip masks the breakpoint for the first instruction after a resume
    assign stop_hit  = halt_word | (bkpt_match & ~skip);
    assign en_o      = (state != ST_HALT) & ~stop_hit;
    assign cmd.ready = (state == ST_HALT) | (cmd.op == OP_HALT)
                     | (cmd.op == OP_CLEAR);
    assign fire      = cmd.valid & cmd.ready;

    assign state_o   = state;
    assign cause_o   = cause;
    assign retired_o = retired;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_HALT;
            cause     <= C_NONE;
            retired   <= '0;
            remaining <= '0;
            skip      <= 1'b0;
        end else begin
            state     <= state_n;
            cause     <= cause_n;
            retired   <= retired_n;
            remaining <= remaining_n;
            skip      <= skip_n;
        end
    end

    always_comb begin
        state_n     = state;
        cause_n     = cause;
        retired_n   = retired;
        remaining_n = remaining;
        skip_n      = skip;

        if (state == ST_HALT) begin
            if (fire && cmd.op == OP_RUN) begin
                state_n = ST_RUN;
                skip_n  = 1'b1;
            end else if (fire && cmd.op == OP_STEP) begin
                state_n     = ST_STEP;
                remaining_n = (cmd.step_cnt == '0) ? STEP_W'(1)
                                                   : cmd.step_cnt;
                skip_n      = 1'b1;
            end
        end else begin
            // host HALT first so that internal causes below override it
            if (fire && cmd.op == OP_HALT) begin
                state_n = ST_HALT;
                cause_n = C_NONE;
            end
            if (stop_hit) begin
                state_n = ST_HALT;
                cause_n = halt_word ? C_HINST : C_BKPT;
            end else begin
                retired_n = retired + 32'd1;
                skip_n    = 1'b0;
                if (state == ST_STEP) begin
                    remaining_n = remaining - STEP_W'(1);
                    if (remaining == STEP_W'(1)) begin
                        state_n = ST_HALT;
                        cause_n = C_STEP;
                    end
                end
            end
        end

        if (fire && cmd.op == OP_CLEAR) begin
            retired_n = '0;
            cause_n   = C_NONE;
        end
    end

endmodule

// File: tb/tb_exec_run_ctrl.sv
// Directed bench for exec_run_ctrl with a cycle-level reference model
// of the run/step/halt rules and a small program-memory environment.
module tb_exec_run_ctrl;

    localparam int PC_W = 9;
    localparam int STEP_W = 16;
    localparam logic [31:0] HW = 32'hFFFF_FFFF;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [PC_W-1:0]   pc_i = '0;
    logic [31:0]       instr_i = '0;
    logic              bkpt_valid_i = 1'b0;
    logic [PC_W-1:0]   bkpt_pc_i = '0;
    logic              en_o;
    logic [1:0]        state_o;
    logic [1:0]        cause_o;
    logic [31:0]       retired_o;

    exec_run_ctrl_if #(.STEP_W(STEP_W)) cmd_bus ();

    exec_run_ctrl #(
        .PC_W(PC_W), .STEP_W(STEP_W), .HALT_INSTR(HW)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .cmd(cmd_bus),
        .pc_i(pc_i),
        .instr_i(instr_i),
        .bkpt_valid_i(bkpt_valid_i),
        .bkpt_pc_i(bkpt_pc_i),
        .en_o(en_o),
        .state_o(state_o),
        .cause_o(cause_o),
        .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef EXEC_RUN_CTRL_BKPT_EN
    localparam bit BKPT_ON = 1'b1;
`else
    localparam bit BKPT_ON = 1'b0;
`endif

    int vecs = 0;
    int bad = 0;
    int en_cnt = 0;

    logic [31:0] mem [0:127];

    // reference model: mode 0 halted, 1 running, 2 stepping
    int          m_mode = 0;
    int          m_rem = 0;
    bit          m_skip = 1'b0;
    logic [31:0] m_ret = '0;
    int          m_cause = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        vecs++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic bit m_stop();
        bit hw, bk;
        hw = (instr_i == HW);
        bk = BKPT_ON && bkpt_valid_i && (pc_i == bkpt_pc_i);
        return hw || (bk && !m_skip);
    endfunction

    function automatic bit m_en();
        return (m_mode != 0) && !m_stop();
    endfunction

    function automatic bit m_ready();
        return (m_mode == 0) || (cmd_bus.op == 2'd0)
            || (cmd_bus.op == 2'd3);
    endfunction

    task automatic m_reset();
        m_mode = 0; m_rem = 0; m_skip = 0; m_ret = '0; m_cause = 0;
    endtask

    // advance the model by one clock using the inputs held over the edge
    task automatic m_update();
        bit fire, en, stop;
        int op;
        fire = cmd_bus.valid && m_ready();
        op = int'(cmd_bus.op);
        en = m_en();
        stop = m_stop();
        if (m_mode == 0) begin
            if (fire && op == 1) begin
                m_mode = 1; m_skip = 1;
            end else if (fire && op == 2) begin
                m_mode = 2; m_skip = 1;
                m_rem = (cmd_bus.step_cnt == 0) ? 1
                      : int'(cmd_bus.step_cnt);
            end
        end else if (stop) begin
            m_mode = 0;
            m_cause = (instr_i == HW) ? 2 : 3;
        end else begin
            m_ret = m_ret + 1;
            m_skip = 0;
            if (m_mode == 2) m_rem = m_rem - 1;
            if (m_mode == 2 && m_rem == 0) begin
                m_mode = 0; m_cause = 1;
            end else if (fire && op == 0) begin
                m_mode = 0; m_cause = 0;
            end
        end
        if (fire && op == 3) begin
            m_ret = '0; m_cause = 0;
        end
        if (en) pc_i = pc_i + PC_W'(4);
    endtask

    // one cycle: starts 1 time unit after a rising edge
    task automatic tick();
        instr_i = mem[pc_i[8:2]];
        #4;
        chk("en", {31'd0, en_o}, {31'd0, m_en()});
        chk("state", {30'd0, state_o}, 32'(m_mode));
        chk("cause", {30'd0, cause_o}, 32'(m_cause));
        chk("retired", retired_o, m_ret);
        chk("ready", {31'd0, cmd_bus.ready}, {31'd0, m_ready()});
        if (en_o) en_cnt++;
        @(posedge clk_i);
        if (rst_i) m_reset();
        else m_update();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic [1:0] op,
                         input logic [STEP_W-1:0] cnt);
        cmd_bus.valid = 1'b1;
        cmd_bus.op = op;
        cmd_bus.step_cnt = cnt;
        tick();
        cmd_bus.valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
        cmd_bus.valid = 1'b0;
        cmd_bus.op = 2'd0;
        cmd_bus.step_cnt = '0;
        #2;
        chk("rst_en", {31'd0, en_o}, 32'd0);
        chk("rst_state", {30'd0, state_o}, 32'd0);
        @(posedge clk_i);
        #1;
        m_reset();
        rst_i = 1'b0;
        ticks(2);

        // STEP 3
        en_cnt = 0;
        issue(2'd2, 16'd3);
        ticks(5);
        chk("t2_en_cnt", 32'(en_cnt), 32'd3);
        chk("t2_state", {30'd0, state_o}, 32'd0);
        chk("t2_cause", {30'd0, cause_o}, 32'd1);
        chk("t2_retired", retired_o, 32'd3);
        // STEP 0 behaves as STEP 1
        en_cnt = 0;
        issue(2'd2, 16'd0);
        ticks(3);
        chk("t2_zero_cnt", 32'(en_cnt), 32'd1);
        chk("t2_zero_ret", retired_o, 32'd4);

        // CLEAR while halted
        issue(2'd3, 16'd0);
        chk("clr_ret", retired_o, 32'd0);
        chk("clr_cause", {30'd0, cause_o}, 32'd0);

        // halt word at the 5th PC
        pc_i = '0;
        mem[4] = HW;
        en_cnt = 0;
        issue(2'd1, 16'd0);
        ticks(7);
        chk("t3_en_cnt", 32'(en_cnt), 32'd4);
        chk("t3_cause", {30'd0, cause_o}, 32'd2);
        chk("t3_retired", retired_o, 32'd4);
        chk("t3_pc", 32'(pc_i), 32'd16);
        // halt word is never executed, even on resume
        en_cnt = 0;
        issue(2'd1, 16'd0);
        ticks(2);
        chk("t3_resume", 32'(en_cnt), 32'd0);
        mem[4] = 32'h0000_0013;

        // HALT command while running; stalled RUN
        pc_i = '0;
        issue(2'd3, 16'd0);
        issue(2'd1, 16'd0);
        ticks(3);
        cmd_bus.valid = 1'b1;
        cmd_bus.op = 2'd1;
        ticks(3);
        chk("t5_stall", {31'd0, cmd_bus.ready}, 32'd0);
        cmd_bus.op = 2'd0;
        tick();
        cmd_bus.valid = 1'b0;
        chk("t5_retired", retired_o, 32'd7);
        ticks(2);
        chk("t5_state", {30'd0, state_o}, 32'd0);
        chk("t5_cause", {30'd0, cause_o}, 32'd0);

        // CLEAR racing a retire, then counter wrap
        pc_i = '0;
        issue(2'd1, 16'd0);
        ticks(2);
        issue(2'd3, 16'd0);
        chk("t6_clr_race", retired_o, 32'd0);
        #2;
        force dut.retired = 32'hFFFF_FFFF;
        m_ret = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        tick();
        chk("t6_wrap", retired_o, 32'd0);
        issue(2'd0, 16'd0);
        ticks(1);

        // breakpoint at PC 8
        pc_i = '0;
        issue(2'd3, 16'd0);
        bkpt_valid_i = 1'b1;
        bkpt_pc_i = PC_W'(8);
        en_cnt = 0;
        issue(2'd1, 16'd0);
        ticks(5);
`ifdef EXEC_RUN_CTRL_BKPT_EN
        chk("t4_en_cnt", 32'(en_cnt), 32'd2);
        chk("t4_cause", {30'd0, cause_o}, 32'd3);
        chk("t4_retired", retired_o, 32'd2);
        chk("t4_pc", 32'(pc_i), 32'd8);
        en_cnt = 0;
        issue(2'd1, 16'd0);
        ticks(3);
        chk("t4_resume", 32'(en_cnt), 32'd3);
        chk("t4_pc2", 32'(pc_i), 32'd20);
`else
        chk("t4_off_cnt", 32'(en_cnt), 32'd5);
`endif
        issue(2'd0, 16'd0);
        ticks(1);
        bkpt_valid_i = 1'b0;

        // async reset mid-RUN
        pc_i = '0;
        issue(2'd1, 16'd0);
        ticks(3);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t1_en", {31'd0, en_o}, 32'd0);
        chk("t1_state", {30'd0, state_o}, 32'd0);
        chk("t1_cause", {30'd0, cause_o}, 32'd0);
        chk("t1_retired", retired_o, 32'd0);
        m_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
